// File: rtl/audio_dac_serializer.sv
// -----------------------------------------------------------------------------
// audio_dac_serializer
//
// Transmit end of the codec audio path. This block is the interface master. It
// divides CLOCK_50 down to the bit clock and the DAC channel-select clock, and
// shifts 16-bit left/right samples MSB first onto the DAC serial data line in
// left-justified format. Data and LRCK change on BCLK falling edges, so they
// are stable at BCLK rising edges.
//
// Upstream hands over L/R pairs through a one-deep holding register that uses
// a valid/ready handshake. At every frame start, the pair to transmit is
// latched into a shadow register pair. If no pair is available at that point,
// the previous pair repeats and the sticky underrun flag is raised.
//
// Ports:
//   CLOCK_50     in   system clock, the only clock
//   reset        in   synchronous, active-high reset
//   audio_outL   in   left sample (two's complement, treated as raw bits)
//   audio_outR   in   right sample (two's complement, treated as raw bits)
//   sample_valid in   L/R pair present on audio_outL/R
//   sample_ready out  holding register empty; accept = valid && ready
//   AUD_BCLK     out  bit clock
//   AUD_DACLRCK  out  channel select, 1 = left slot, 0 = right slot
//   AUD_DACDAT   out  serial data
//   frame_start  out  one-cycle pulse when a new frame (left slot) begins
//   underrun     out  sticky flag; a frame started with no new pair available
// -----------------------------------------------------------------------------
module audio_dac_serializer #(
  parameter int DATA_WIDTH = 16,
  parameter int SLOT_BITS  = 32,
  parameter int BCLK_HALF  = 8
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] audio_outL,
  input  logic [DATA_WIDTH-1:0] audio_outR,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  output logic                  AUD_BCLK,
  output logic                  AUD_DACLRCK,
  output logic                  AUD_DACDAT,
  output logic                  frame_start,
  output logic                  underrun
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int DIV_W      = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam int BIT_W      = $clog2(FRAME_BITS);
  // The per-bit lookup vector is padded to a power of two. This lets the
  // frame bit counter index it directly, with no range check.
  localparam int BIT_SPAN   = 1 << BIT_W;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0] SLOT_LEN = BIT_W'(SLOT_BITS);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0]      div_q,         div_d;
  logic                  bclk_q,        bclk_d;
  logic [BIT_W-1:0]      bit_cnt_q,     bit_cnt_d;
  logic                  lrck_q,        lrck_d;
  logic                  dacdat_q,      dacdat_d;
  logic                  frame_start_q, frame_start_d;
  logic                  underrun_q,    underrun_d;
  logic                  hold_full_q,   hold_full_d;
  logic [DATA_WIDTH-1:0] hold_l_q,      hold_l_d;
  logic [DATA_WIDTH-1:0] hold_r_q,      hold_r_d;
  logic [DATA_WIDTH-1:0] shadow_l_q,    shadow_l_d;
  logic [DATA_WIDTH-1:0] shadow_r_q,    shadow_r_d;

  logic                  div_tc;
  logic                  fall_evt;
  logic                  frame_evt;
  logic                  accept;
  logic [BIT_SPAN-1:0]   frame_bits;

  // ---------------------------------------------------------------------------
  // Bit-clock divider and frame bit counter
  // ---------------------------------------------------------------------------
  always_comb begin
    div_tc    = (div_q == DIV_LAST);
    // BCLK is about to go 1->0. All serial outputs advance on this event.
    fall_evt  = div_tc && bclk_q;
    // The falling edge that wraps the bit counter opens a new left slot.
    frame_evt = fall_evt && (bit_cnt_q == BIT_LAST);

    div_d     = div_tc ? '0 : div_q + DIV_W'(1);
    bclk_d    = div_tc ? ~bclk_q : bclk_q;
    bit_cnt_d = bit_cnt_q;
    lrck_d    = lrck_q;

    if (fall_evt) begin
      bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + BIT_W'(1);
      lrck_d    = (bit_cnt_d < SLOT_LEN);
    end
  end

  // ---------------------------------------------------------------------------
  // Handshake, holding register and shadow load
  // ---------------------------------------------------------------------------
  assign accept       = sample_valid && !hold_full_q;
  assign sample_ready = ~hold_full_q;

  always_comb begin
    hold_full_d   = hold_full_q;
    hold_l_d      = hold_l_q;
    hold_r_d      = hold_r_q;
    shadow_l_d    = shadow_l_q;
    shadow_r_d    = shadow_r_q;
    underrun_d    = underrun_q;
    frame_start_d = 1'b0;

    if (frame_evt) begin
      frame_start_d = 1'b1;
      if (hold_full_q) begin
        // A queued pair moves to the shadow. While the holding register is
        // full, sample_valid is ignored, so it is not reloaded here.
        shadow_l_d  = hold_l_q;
        shadow_r_d  = hold_r_q;
        hold_full_d = 1'b0;
      end else if (sample_valid) begin
        // Bypass: a pair that arrives exactly at frame start goes straight out.
        shadow_l_d = audio_outL;
        shadow_r_d = audio_outR;
      end else begin
        // Nothing new. The old pair repeats and the miss is remembered.
        underrun_d = 1'b1;
      end
    end else if (accept) begin
      hold_l_d    = audio_outL;
      hold_r_d    = audio_outR;
      hold_full_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Serial bit lookup: frame_bits[n] is the bit driven at frame position n.
  // It is built from the next shadow value, so the MSB driven at frame start
  // already reflects the pair loaded in that same cycle.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < BIT_SPAN; gi++) begin : g_frame_bits
      if ((gi < DATA_WIDTH) && (gi < SLOT_BITS)) begin : g_left
        assign frame_bits[gi] = shadow_l_d[DATA_WIDTH-1-gi];
      end else if ((gi >= SLOT_BITS) && (gi < FRAME_BITS) &&
                   ((gi - SLOT_BITS) < DATA_WIDTH)) begin : g_right
        assign frame_bits[gi] = shadow_r_d[DATA_WIDTH-1-(gi-SLOT_BITS)];
      end else begin : g_pad
        assign frame_bits[gi] = 1'b0;
      end
    end
  endgenerate

  always_comb begin
    dacdat_d = dacdat_q;
    if (fall_evt) begin
      dacdat_d = frame_bits[bit_cnt_d];
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      // Reset aborts the frame in progress and discards any queued pair. The
      // bit counter restarts one position before the frame wrap, so the first
      // falling edge after reset opens a fresh frame.
      div_q         <= '0;
      bclk_q        <= 1'b0;
      bit_cnt_q     <= BIT_LAST;
      lrck_q        <= 1'b0;
      dacdat_q      <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      hold_full_q   <= 1'b0;
      hold_l_q      <= '0;
      hold_r_q      <= '0;
      shadow_l_q    <= '0;
      shadow_r_q    <= '0;
    end else begin
      div_q         <= div_d;
      bclk_q        <= bclk_d;
      bit_cnt_q     <= bit_cnt_d;
      lrck_q        <= lrck_d;
      dacdat_q      <= dacdat_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
      hold_full_q   <= hold_full_d;
      hold_l_q      <= hold_l_d;
      hold_r_q      <= hold_r_d;
      shadow_l_q    <= shadow_l_d;
      shadow_r_q    <= shadow_r_d;
    end
  end

  assign AUD_BCLK    = bclk_q;
  assign AUD_DACLRCK = lrck_q;
  assign AUD_DACDAT  = dacdat_q;
  assign frame_start = frame_start_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_audio_dac_serializer.sv
// -----------------------------------------------------------------------------
// tb_audio_dac_serializer
//
// Directed bench for audio_dac_serializer with default parameters (16-bit
// samples, 32-bit slots, BCLK = CLOCK_50/16, 1024-cycle frame). Inputs are
// driven and outputs sampled on the CLOCK_50 falling edge. Time is counted in
// rising edges since reset release, so the first frame starts at edge 16.
// -----------------------------------------------------------------------------
module tb_audio_dac_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] aud_l;
  logic [15:0] aud_r;
  logic        sample_valid;
  logic        sample_ready;
  logic        aud_bclk;
  logic        aud_lrck;
  logic        aud_dat;
  logic        frame_start;
  logic        underrun;

  int n_tests = 0;
  int n_fail  = 0;

  audio_dac_serializer #(
    .DATA_WIDTH (16),
    .SLOT_BITS  (32),
    .BCLK_HALF  (8)
  ) dut (
    .CLOCK_50     (clk),
    .reset        (rst),
    .audio_outL   (aud_l),
    .audio_outR   (aud_r),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .AUD_BCLK     (aud_bclk),
    .AUD_DACLRCK  (aud_lrck),
    .AUD_DACDAT   (aud_dat),
    .frame_start  (frame_start),
    .underrun     (underrun)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".bclk"},  64'(aud_bclk),     64'd0);
    chk({tag, ".lrck"},  64'(aud_lrck),     64'd0);
    chk({tag, ".dat"},   64'(aud_dat),      64'd0);
    chk({tag, ".fs"},    64'(frame_start),  64'd0);
    chk({tag, ".ur"},    64'(underrun),     64'd0);
    chk({tag, ".ready"}, 64'(sample_ready), 64'd1);
  endtask

  // Call at the negedge one cycle before a frame start (edge F-1). The task
  // checks the frame-start cycle, then captures the 64 slot bits at every BCLK
  // rising edge and BCLK low at every falling edge. It returns at edge F+1016.
  task automatic run_frame(input string tag, input logic [63:0] exp_data,
                           input logic ur_pre, input logic ur_post,
                           input logic rdy_f, input logic rdy_f1,
                           input logic keep_valid);
    logic [63:0] dat;
    logic [63:0] lr;
    logic [63:0] bhi;
    logic [62:0] blo;
    chk({tag, ".fs_pre"},   64'(frame_start), 64'd0);
    chk({tag, ".ur_pre"},   64'(underrun),    64'(ur_pre));
    chk({tag, ".bclk_pre"}, 64'(aud_bclk),    64'd1);
    tick(1);
    chk({tag, ".fs"},    64'(frame_start),  64'd1);
    chk({tag, ".ur"},    64'(underrun),     64'(ur_post));
    chk({tag, ".lrck0"}, 64'(aud_lrck),     64'd1);
    chk({tag, ".msb"},   64'(aud_dat),      64'(exp_data[63]));
    chk({tag, ".rdy_f"}, 64'(sample_ready), 64'(rdy_f));
    if (!keep_valid) sample_valid = 1'b0;
    tick(1);
    chk({tag, ".fs_post"}, 64'(frame_start),  64'd0);
    chk({tag, ".rdy_f1"},  64'(sample_ready), 64'(rdy_f1));
    sample_valid = 1'b0;
    tick(7);
    for (int n = 0; n < 64; n++) begin
      dat[63-n] = aud_dat;
      lr[63-n]  = aud_lrck;
      bhi[63-n] = aud_bclk;
      if (n < 63) begin
        tick(8);
        blo[62-n] = aud_bclk;
        tick(8);
      end
    end
    chk({tag, ".data"},    dat, exp_data);
    chk({tag, ".lrck"},    lr,  {32'hFFFF_FFFF, 32'h0});
    chk({tag, ".bclk_hi"}, bhi, {64{1'b1}});
    chk({tag, ".bclk_lo"}, 64'(blo), 64'd0);
  endtask

  initial begin
    rst          = 1'b1;
    aud_l        = 16'h0;
    aud_r        = 16'h0;
    sample_valid = 1'b0;

    // Reset for 3 cycles: every output is in its reset state.
    tick(3);
    chk_reset_vals("rst_init");
    rst = 1'b0;                      // t = 0

    // One pair arrives before the first frame.
    tick(2);
    chk("pre.ready", 64'(sample_ready), 64'd1);
    aud_l = 16'hA5C3; aud_r = 16'h8001; sample_valid = 1'b1;
    tick(1);                         // accepted at edge 3
    sample_valid = 1'b0;
    chk("pre.held", 64'(sample_ready), 64'd0);
    tick(12);                        // t = 15
    run_frame("f0", {16'hA5C3, 16'h0, 16'h8001, 16'h0}, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick(7);

    // No new pairs: the frame repeats and underrun rises, then stays set.
    run_frame("f1", {16'hA5C3, 16'h0, 16'h8001, 16'h0}, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    tick(7);
    run_frame("f2", {16'hA5C3, 16'h0, 16'h8001, 16'h0}, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

    // Back-to-back pairs mid-frame. The second pair waits for the holding slot.
    aud_l = 16'h1111; aud_r = 16'h2222; sample_valid = 1'b1;
    tick(1);
    chk("bb.first_acc", 64'(sample_ready), 64'd0);
    aud_l = 16'h3333; aud_r = 16'h4444;
    tick(6);
    chk("bb.held_off", 64'(sample_ready), 64'd0);
    run_frame("f3", {16'h1111, 16'h0, 16'h2222, 16'h0}, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    tick(7);
    run_frame("f4", {16'h3333, 16'h0, 16'h4444, 16'h0}, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

    // Reset at left-slot bit 10 while a pair is held.
    tick(7);
    tick(1);                         // frame start F5, shadow repeats 3333/4444
    chk("f5.fs", 64'(frame_start), 64'd1);
    aud_l = 16'h5555; aud_r = 16'h6666; sample_valid = 1'b1;
    tick(1);
    sample_valid = 1'b0;
    chk("f5.held", 64'(sample_ready), 64'd0);
    tick(169);                       // F5+170: bit 10, BCLK high
    chk("f5.lrck",  64'(aud_lrck),     64'd1);
    chk("f5.bit10", 64'(aud_dat),      64'd1);
    chk("f5.bclk",  64'(aud_bclk),     64'd1);
    chk("f5.ur",    64'(underrun),     64'd1);
    rst = 1'b1;
    tick(1);
    chk_reset_vals("rst_mid");
    rst = 1'b0;                      // t = 0
    tick(15);
    run_frame("rst6", 64'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);

    // Fresh reset, then bypass: the pair is valid only in the frame-start cycle.
    rst = 1'b1;
    tick(3);
    chk_reset_vals("rst_byp");
    rst = 1'b0;                      // t = 0
    tick(15);
    aud_l = 16'h7FFF; aud_r = 16'h0000; sample_valid = 1'b1;
    run_frame("byp", {16'h7FFF, 16'h0, 16'h0000, 16'h0}, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
